// File: rtl/cdb_arbiter_pkg.sv
// Shared types and helpers for the common data bus arbiter and its source buffers.
package cdb_arbiter_pkg;

  localparam int PREG_W = 7;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;

  // Fixed source ordering on the bus
  localparam logic [1:0] CDB_SRC_ALU = 2'd0;
  localparam logic [1:0] CDB_SRC_B   = 2'd1;
  localparam logic [1:0] CDB_SRC_MEM = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] preg;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              we;
  } cdb_entry_t;

  // True when tag is strictly younger than ref_tag, measuring both as the
  // wrapped distance from the ROB head. An equal tag is not younger.
  function automatic logic rob_younger(input logic [TAG_W-1:0] tag,
                                       input logic [TAG_W-1:0] ref_tag,
                                       input logic [TAG_W-1:0] head);
    logic [TAG_W-1:0] age_t;
    logic [TAG_W-1:0] age_r;
    age_t = tag - head;
    age_r = ref_tag - head;
    return age_t > age_r;
  endfunction

endpackage

// File: rtl/cdb_src_buffer.sv
// In-order holding buffer for one completion source. Entry 0 is the head.
// Supports same-cycle push/pop and age-based squash with compaction.
module cdb_src_buffer
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  cdb_entry_t       push_ent_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [TAG_W-1:0] flush_tag_i,
  input  logic [TAG_W-1:0] rob_head_i,
  output logic             ready_o,
  output cdb_entry_t       head_o
);

  localparam int CW = $clog2(DEPTH + 1);

  cdb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   keep;
  logic                   push_keep;

  // Rebuild the buffer: drop the popped head and squashed entries, pack the
  // survivors toward entry 0, then append the incoming entry if it survives.
  always_comb begin
    ent_d     = '0;
    cnt_d     = '0;
    keep      = 1'b0;
    push_keep = push_i & ~(flush_i & rob_younger(push_ent_i.tag, flush_tag_i, rob_head_i));
    for (int i = 0; i < DEPTH; i++) begin
      keep = ent_q[i].valid & ~(pop_i && i == 0)
           & ~(flush_i & rob_younger(ent_q[i].tag, flush_tag_i, rob_head_i));
      if (keep) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (CW'(j) == cnt_d) ent_d[j] = ent_q[i];
        end
        cnt_d = cnt_d + CW'(1);
      end
    end
    if (push_keep) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (CW'(j) == cnt_d) begin
          ent_d[j]       = push_ent_i;
          ent_d[j].valid = 1'b1;
        end
      end
      cnt_d = cnt_d + CW'(1);
    end
  end

  // Buffer storage and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  // Ready depends only on registered occupancy, never on the same-cycle pop
  assign ready_o = (cnt_q < CW'(DEPTH));
  assign head_o  = ent_q[0];

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU/branch/LSU completions and broadcasts
// one per cycle, round-robin, through a registered CDB. Mispredicts squash
// buffered, incoming and winning results younger than the branch.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NSRC  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NSRC-1:0]              req_valid,
  output logic [NSRC-1:0]              req_ready,
  input  logic [NSRC-1:0][PREG_W-1:0]  req_preg,
  input  logic [NSRC-1:0][TAG_W-1:0]   req_tag,
  input  logic [NSRC-1:0][DATA_W-1:0]  req_data,
  input  logic [NSRC-1:0]              req_we,
  input  logic [TAG_W-1:0]             rob_head,
  input  logic                         mispredict,
  input  logic [TAG_W-1:0]             mispredict_tag,
  output logic                         cdb_valid,
  output logic [1:0]                   cdb_src,
  output logic [PREG_W-1:0]            cdb_preg,
  output logic [TAG_W-1:0]             cdb_tag,
  output logic [DATA_W-1:0]            cdb_data,
  output logic                         cdb_we
);

  cdb_entry_t [NSRC-1:0] push_ent;
  cdb_entry_t [NSRC-1:0] head_ent;
  logic [NSRC-1:0]       push;
  logic [NSRC-1:0]       pop;

  logic [1:0]            rr_q, rr_d;
  logic [1:0]            win_idx;
  logic                  win_found;
  logic                  win_young;
  cdb_entry_t            win_ent;

  logic                  cdb_valid_q, cdb_valid_d;
  logic [1:0]            cdb_src_q;
  logic [PREG_W-1:0]     cdb_preg_q;
  logic [TAG_W-1:0]      cdb_tag_q;
  logic [DATA_W-1:0]     cdb_data_q;
  logic                  cdb_we_q;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign push_ent[g] = {1'b1, req_preg[g], req_tag[g], req_data[g], req_we[g]};
    assign push[g]     = req_valid[g] & req_ready[g];
    assign pop[g]      = win_found & (win_idx == 2'(g));

    cdb_src_buffer #(.DEPTH(DEPTH)) u_buf (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push[g]),
      .push_ent_i  (push_ent[g]),
      .pop_i       (pop[g]),
      .flush_i     (mispredict),
      .flush_tag_i (mispredict_tag),
      .rob_head_i  (rob_head),
      .ready_o     (req_ready[g]),
      .head_o      (head_ent[g])
    );
  end

  // Round-robin search from rr_q; iterate farthest-first so the nearest
  // nonempty source is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      for (int s = 0; s < NSRC; s++) begin
        if (head_ent[s].valid && ((int'(rr_q) + k) % NSRC == s)) begin
          win_found = 1'b1;
          win_idx   = 2'(s);
        end
      end
    end
  end

  // Winner mux, squash qualification and pointer advance. A squashed winner
  // still consumes its slot and moves the pointer past its source.
  always_comb begin
    win_ent = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (2'(s) == win_idx) win_ent = head_ent[s];
    end
    win_young   = mispredict & rob_younger(win_ent.tag, mispredict_tag, rob_head);
    cdb_valid_d = win_found & ~win_young;
    rr_d        = rr_q;
    if (win_found) rr_d = (win_idx == 2'(NSRC - 1)) ? '0 : win_idx + 2'd1;
  end

  // Round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= CDB_SRC_ALU;
    else        rr_q <= rr_d;
  end

  // CDB output register; payload holds when nothing is broadcast
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= CDB_SRC_ALU;
      cdb_preg_q  <= '0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_we_q    <= 1'b0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_we_q    <= cdb_valid_d & win_ent.we;
      if (cdb_valid_d) begin
        cdb_src_q  <= win_idx;
        cdb_preg_q <= win_ent.preg;
        cdb_tag_q  <= win_ent.tag;
        cdb_data_q <= win_ent.data;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_src   = cdb_src_q;
  assign cdb_preg  = cdb_preg_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_we    = cdb_we_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares one registered common data bus (CDB) between the three completion sources: ALU, branch unit and LSU.
- Each source gets a small in-order holding buffer with a valid/ready handshake. A round-robin scheduler picks one buffered result per cycle to broadcast to the PRF write port, ROB completion and dispatch wakeup.
- On a branch mispredict, buffered and in-flight results younger than the mispredicting ROB tag are squashed.
- Sits between the `fus` outputs and the PRF/ROB/dispatch consumers.

## Interface
Parameters:
- DEPTH, 2, entries per source buffer (≥2)
- NSRC, 3, number of sources; fixed order 0=ALU, 1=branch, 2=LSU

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- req_valid  in  NSRC  source i presents a result
- req_ready  out  NSRC  source i buffer can accept
- req_preg  in  NSRC×7  destination physical register
- req_tag  in  NSRC×5  ROB tag of the result
- req_data  in  NSRC×32  result value
- req_we  in  NSRC  result writes a register (0 for stores and branches without rd)
- rob_head  in  5  oldest in-flight ROB tag
- mispredict  in  1  single-cycle flush pulse
- mispredict_tag  in  5  ROB tag of the mispredicting branch
- cdb_valid  out  1  broadcast valid
- cdb_src  out  2  winning source index
- cdb_preg  out  7  broadcast physical register
- cdb_tag  out  5  broadcast ROB tag
- cdb_data  out  32  broadcast value
- cdb_we  out  1  PRF write enable (cdb_valid & entry.we)

## Operation
- **Accept.** The handshake fires when req_valid[i] & req_ready[i] at a rising edge; the entry is appended at the tail of buffer i.
- **Ready.** req_ready[i] = (count_i < DEPTH). It is a function of registered state only, with no combinational path from the same-cycle pop.
- **Buffers.** Each buffer is in-order with entry 0 as head. Every entry holds {valid, preg, tag, data, we}.
- **Round-robin.** rr_ptr is 2 bits, range 0..2, reset 0.
  - Each cycle, search nonempty buffers starting at rr_ptr, in the order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - The winner's head is popped and loaded into the CDB output register at the edge.
  - rr_ptr then becomes (winner+1) mod 3. If there is no winner, rr_ptr holds.
- **Age.** age(t) = (t − rob_head) mod 32, computed as a 5-bit unsigned subtraction with wrap. An entry is younger than the branch iff age(entry.tag) > age(mispredict_tag). An equal tag is kept, so the branch's own result survives.
- **Flush.** On an edge with mispredict=1, all of the following use pre-edge contents:
  - Younger buffer entries are removed and the survivors compacted toward entry 0, preserving order.
  - The CDB register loads only if the selected winner is not younger; otherwise cdb_valid=0. The arbitration slot is not retried.
  - A request handshaking in the same cycle is discarded if younger. It still counts as accepted, so the source must not retry it.
  - The current CDB register contents are not recalled. They were already broadcast during that cycle.
- **Simultaneous events.** A push and pop on the same buffer in one cycle is legal when not full. The count is unchanged and order is preserved.
- **No ordering across sources.** Only per-source order is guaranteed.

## Timing
- **Reset.** While reset=0 (asynchronous):
  - all buffers are empty;
  - rr_ptr=0;
  - cdb_valid=0, cdb_src=0, cdb_preg=0, cdb_tag=0, cdb_data=0, cdb_we=0;
  - req_ready is all 1s once reset deasserts.
- **Reset mid-operation.** Discards all buffered results. Release is synchronised by the surrounding logic.
- **Latency.** An entry accepted at edge N appears on the CDB at the earliest in the cycle after edge N+1, i.e. 2 edges from handshake to broadcast.
- **cdb_valid.** Asserted for exactly one cycle per broadcast entry. There is no backpressure from consumers.
- **Throughput.** 1 broadcast per cycle in aggregate.
- **Starvation bound.** A nonempty buffer's head is granted within 3 cycles.
- **Full to ready.** Popping a full buffer raises req_ready the cycle after the pop edge.

## Structure
- types_pkg gains:
  - typedef cdb_entry {logic valid; logic [6:0] preg; logic [4:0] tag; logic [31:0] data; logic we;};
  - constants CDB_SRC_ALU=0, CDB_SRC_B=1, CDB_SRC_MEM=2;
  - function rob_younger(tag, ref_tag, head), which is reused by the LSQ and RS flush logic.
- Sub-module cdb_src_buffer: the DEPTH-entry in-order buffer with push, pop, count, ready and age-based squash/compaction. It is instantiated NSRC times.
- The arbiter proper contains rr_ptr, the winner mux and the CDB output register.

## Test plan
1. **Reset and single result.** Reset low mid-traffic, then release; send ALU result {preg=12, tag=3, data=0xDEAD, we=1}.
   - Expect: all outputs are 0 during reset.
   - Expect: one cycle of cdb_valid, cdb_src=0, preg=12, tag=3, data=0xDEAD, cdb_we=1, two edges after the handshake.
2. **Round-robin fairness.** All three sources stream continuously.
   - Expect: cdb_src sequence 0,1,2,0,1,2.
   - Expect: no source ever waits more than 3 cycles.
3. **Backpressure.** DEPTH=2; LSU pushes 3 results back-to-back while ALU and branch saturate the bus.
   - Expect: req_ready[2]=0 after 2 accepts.
   - Expect: it rises the cycle after the first LSU pop, and all 3 LSU results are broadcast in order.
4. **Flush with wrap.** rob_head=30; buffered tags 31, 1 (ALU) and 2 (LSU); mispredict_tag=0.
   - Expect: tag 31 survives; tags 1 and 2 are squashed.
   - Expect: the same-cycle incoming tag 5 is dropped; a branch result with tag 0 is still broadcast.
5. **Flush versus winner.** A flush arrives in the same cycle the winner's head is younger.
   - Expect: cdb_valid=0 next cycle.
   - Expect: rr_ptr advances past that source, and older entries continue normally.
6. **Stores and branches without rd.** Send req_we=0 entries.
   - Expect: cdb_valid=1 with cdb_we=0, so the ROB completes the entry without a PRF write.
